mar_burst_gen: RTL and testbench



---
 rtl/mar_burst_gen_pkg.sv | 13 +
 rtl/mar_burst_gen_if.sv | 27 ++
 rtl/mar_burst_gen_port_b_map.sv | 23 ++
 rtl/mar_burst_gen.sv | 108 ++++++++++
 tb/tb_mar_burst_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mar_burst_gen_pkg.sv
// Shared types and port-B mode codes for the burst address generator.
package mar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [1:0] BMODE_CPL = 2'd0;
  localparam logic [1:0] BMODE_MIR = 2'd1;
  localparam logic [1:0] BMODE_NXT = 2'd2;

endpackage

// File: rtl/mar_burst_gen_if.sv
// Request/handshake bundle between the controller and the burst address generator.
interface mar_burst_gen_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic [1:0]        b_mode;
  logic              abort;
  logic              ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              valid;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, start_len, b_mode, abort, ready,
    input  addr_a, addr_b, valid, busy, done
  );

  modport slave (
    input  start, start_addr, start_len, b_mode, abort, ready,
    output addr_a, addr_b, valid, busy, done
  );
endinterface

// File: rtl/mar_burst_gen_port_b_map.sv
// Port-B address derivation: complement, mirror or next address of port A.
module mar_port_b_map
  import mar_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int STRIDE = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addrB
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  // Mode 3 is not a defined mapping and falls back to complement.
  always_comb begin
    addrB = ~addr;
    case (mode)
      BMODE_MIR: addrB = addr;
      BMODE_NXT: addrB = addr + STEP;
      default:   addrB = ~addr;
    endcase
  end
endmodule

// File: rtl/mar_burst_gen.sv
// Burst address generator: latches a base address, then steps it by STRIDE per accepted beat.
// state | meaning:  IDLE | waiting for start ;  BURST | beats outstanding on valid/ready
module mar_burst_gen
  import mar_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 4,
  parameter int STRIDE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mar_burst_gen_if.slave bus
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] addrAQ, addrAD;
  logic [ADDR_W-1:0] addrBQ, addrBD;
  logic [ADDR_W-1:0] addrNext, mapIn, mapOut;
  logic [LEN_W-1:0]  remQ, remD;
  logic [1:0]        modeQ, modeD, mapMode;
  logic              validQ, validD;
  logic              busyQ;
  logic              doneQ, doneD;

  // One mapper serves both the first beat (live inputs) and later beats (registered mode).
  assign addrNext = addrAQ + STEP;
  assign mapIn    = (stateQ == IDLE) ? bus.start_addr : addrNext;
  assign mapMode  = (stateQ == IDLE) ? bus.b_mode : modeQ;

  mar_port_b_map #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) uMap (
    .addr  (mapIn),
    .mode  (mapMode),
    .addrB (mapOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      addrAQ <= '0;
      addrBQ <= '0;
      remQ   <= '0;
      modeQ  <= '0;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      addrAQ <= addrAD;
      addrBQ <= addrBD;
      remQ   <= remD;
      modeQ  <= modeD;
      validQ <= validD;
      busyQ  <= (stateD == BURST);
      doneQ  <= doneD;
    end
  end

  always_comb begin
    stateD = stateQ;
    addrAD = addrAQ;
    addrBD = addrBQ;
    remD   = remQ;
    modeD  = modeQ;
    validD = validQ;
    doneD  = 1'b0;
    if (bus.abort) begin
      stateD = IDLE;
      validD = 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (bus.start) begin
            addrAD = bus.start_addr;
            addrBD = mapOut;
            remD   = bus.start_len;
            modeD  = bus.b_mode;
            validD = 1'b1;
            stateD = BURST;
          end
        end
        BURST: begin
          if (validQ && bus.ready) begin
            if (remQ != '0) begin
              addrAD = addrNext;
              addrBD = mapOut;
              remD   = remQ - 1'b1;
            end else begin
              validD = 1'b0;
              doneD  = 1'b1;
              stateD = IDLE;
            end
          end
        end
        default: stateD = IDLE;
      endcase
    end
  end

  assign bus.addr_a = addrAQ;
  assign bus.addr_b = addrBQ;
  assign bus.valid  = validQ;
  assign bus.busy   = busyQ;
  assign bus.done   = doneQ;
endmodule

// File: tb/tb_mar_burst_gen.sv
// Self-checking bench for mar_burst_gen against a beat-index address model.
module tb_mar_burst_gen;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 4;
  localparam int STRIDE = 1;
  localparam int AMOD   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mar_burst_gen_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mar_burst_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STRIDE(STRIDE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Address of beat k and its port-B image, from plain modular arithmetic.
  function automatic logic [ADDR_W-1:0] beatAddr(input int base, input int k);
    return ADDR_W'((base + k * STRIDE) % AMOD);
  endfunction

  function automatic logic [ADDR_W-1:0] refB(input logic [ADDR_W-1:0] a, input int mode);
    int ai;
    ai = int'(a);
    case (mode)
      1:       return ADDR_W'(ai);
      2:       return ADDR_W'((ai + STRIDE) % AMOD);
      default: return ADDR_W'((AMOD - 1) - ai);
    endcase
  endfunction

  // Runs one burst from a negedge in IDLE; ends on the negedge showing done.
  task automatic run_burst(input int base, input int len, input int mode,
                           input int stallAt, input int stallLen, input bit randStall,
                           input string name);
    int k = 0;
    int stalled = 0;
    int cyc = 0;
    bit rdy;
    logic [ADDR_W-1:0] expA, expB;
    logic [2*ADDR_W+2:0] got, exp;
    bus.start      = 1'b1;
    bus.start_addr = ADDR_W'(base);
    bus.start_len  = LEN_W'(len);
    bus.b_mode     = 2'(mode);
    bus.ready      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (k <= len && cyc < 400) begin
      cyc++;
      expA = beatAddr(base, k);
      expB = refB(expA, mode);
      got  = {bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b};
      exp  = {1'b1, 1'b1, 1'b0, expA, expB};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s beat%0d: got v/b/d=%b%b%b a=%h b=%h, want 110 a=%h b=%h",
                 name, k, bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b, expA, expB);
      end
      rdy = 1'b1;
      if (k == stallAt && stalled < stallLen) begin
        rdy = 1'b0;
        stalled++;
      end else if (randStall && ($urandom % 3 == 0)) begin
        rdy = 1'b0;
      end
      bus.ready  = rdy;
      bus.b_mode = 2'($urandom);
      @(negedge clk);
      if (rdy) k++;
    end
    bus.ready = 1'b0;
    checks++;
    if (k != len + 1) begin
      errors++;
      $display("FAIL %s accepts: got %0d in budget, want %0d", name, k, len + 1);
    end
    expA = beatAddr(base, len);
    expB = refB(expA, mode);
    got  = {bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b};
    exp  = {1'b0, 1'b0, 1'b1, expA, expB};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s done: got v/b/d=%b%b%b a=%h b=%h, want 001 a=%h b=%h",
               name, bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b, expA, expB);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.start_addr = 11'h155; bus.start_len = 4'd3;
    bus.b_mode = 2'd1; bus.abort = 1'b0; bus.ready = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got v/b/d=%b%b%b a=%h b=%h, want all 0",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_release: got v/b/d=%b%b%b a=%h b=%h, want all 0",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    bus.ready = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(11'h005, 2, 0, -1, 0, 1'b0, "cpl_basic");
  endtask

  task automatic test_wrap();
    run_burst(11'h7FE, 3, 2, -1, 0, 1'b0, "nxt_wrap");
  endtask

  task automatic test_stall();
    run_burst(11'h010, 3, 1, 1, 3, 1'b0, "stall_mir");
  endtask

  // Starting on the done cycle must be accepted immediately.
  task automatic test_back_to_back();
    run_burst(11'h3F0, 1, 2, -1, 0, 1'b0, "b2b_first");
    run_burst(11'h7FF, 2, 0, -1, 0, 1'b0, "b2b_second");
    @(negedge clk);
    checks++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle: got v/b/d=%b%b%b, want 000", bus.valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_burst(int'($urandom_range(AMOD - 1, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(3, 0)), -1, 0, 1'b1, "random");
    end
  endtask

  task automatic test_abort();
    logic [2*ADDR_W+2:0] got;
    bus.start = 1'b1; bus.start_addr = 11'h100; bus.start_len = 4'd7;
    bus.b_mode = 2'd0; bus.ready = 1'b1;
    @(negedge clk);
    bus.start_addr = 11'h200;
    @(negedge clk);
    bus.start = 1'b0;
    got = {bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b};
    checks++;
    if (got !== {3'b110, 11'h101, 11'h6FE}) begin
      errors++;
      $display("FAIL start_while_busy: got v/b/d=%b%b%b a=%h b=%h, want 110 a=101 b=6fe",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    @(negedge clk);
    bus.abort = 1'b1;
    bus.ready = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    got = {bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b};
    checks++;
    if (got !== {3'b000, 11'h102, 11'h6FD}) begin
      errors++;
      $display("FAIL abort: got v/b/d=%b%b%b a=%h b=%h, want 000 a=102 b=6fd",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    bus.start = 1'b1; bus.abort = 1'b1; bus.start_addr = 11'h300;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    got = {bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b};
    checks++;
    if (got !== {3'b000, 11'h102, 11'h6FD}) begin
      errors++;
      $display("FAIL start_abort: got v/b/d=%b%b%b a=%h b=%h, want 000 a=102 b=6fd",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1; bus.start_addr = 11'h040; bus.start_len = 4'd5;
    bus.b_mode = 2'd2; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v/b/d=%b%b%b a=%h b=%h, want all 0",
               bus.valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    bus.ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_burst(11'h020, 0, 1, -1, 0, 1'b0, "post_reset");
    @(negedge clk);
    checks++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL done_single: got v/b/d=%b%b%b, want 000", bus.valid, bus.busy, bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
